// File: rtl/idex_alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : idex_alu_ctrl_pkg
// Description : Opcode/funct encodings, ALU operation codes, immediate types
//               and the decode record shared by the ID/EX ALU control slice.
// Revision    : 1.0 - initial release
// ============================================================================
package idex_alu_ctrl_pkg;

    // Major opcodes of the supported RV32I subset
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_SHAMT = 3'd2,
        IMM_S     = 3'd3,
        IMM_B     = 3'd4,
        IMM_U     = 3'd5,
        IMM_J     = 3'd6
    } imm_type_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alub_sel;
        imm_type_e  imm_type;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       illegal;
    } decode_t;

    // Decode of an unsupported instruction: no operands, no write-back
    localparam decode_t DEC_ILLEGAL = '{
        alu_op   : ALU_ADD,
        alub_sel : 1'b0,
        imm_type : IMM_NONE,
        rs1      : 5'd0,
        rs2      : 5'd0,
        rd       : 5'd0,
        illegal  : 1'b1
    };

    function automatic logic is_branch_f3(input logic [2:0] f3);
        return (f3 == F3_BEQ)  || (f3 == F3_BNE)  || (f3 == F3_BLT) ||
               (f3 == F3_BGE)  || (f3 == F3_BLTU) || (f3 == F3_BGEU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/idex_alu_ctrl_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : idex_alu_ctrl_imm_gen
// Description : Combinational immediate generator; extracts and sign-extends
//               the immediate selected by the decoded immediate type.
// Revision    : 1.0 - initial release
// ============================================================================
module idex_alu_ctrl_imm_gen
    import idex_alu_ctrl_pkg::*;
(
    input  logic [31:0] i_inst,
    input  imm_type_e   i_imm_type,
    output logic [31:0] o_imm
);

    logic w_sign;
    logic w_unused_opcode;

    assign w_sign          = i_inst[31];
    assign w_unused_opcode = &{1'b0, i_inst[6:0]};

    always_comb begin
        o_imm = 32'd0;
        case (i_imm_type)
            IMM_I:     o_imm = {{20{w_sign}}, i_inst[31:20]};
            IMM_SHAMT: o_imm = {27'd0, i_inst[24:20]};
            IMM_S:     o_imm = {{20{w_sign}}, i_inst[31:25], i_inst[11:7]};
            IMM_B:     o_imm = {{19{w_sign}}, i_inst[31], i_inst[7],
                                i_inst[30:25], i_inst[11:8], 1'b0};
            IMM_U:     o_imm = {i_inst[31:12], 12'd0};
            IMM_J:     o_imm = {{11{w_sign}}, i_inst[31], i_inst[19:12],
                                i_inst[20], i_inst[30:21], 1'b0};
            default:   o_imm = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/idex_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : idex_alu_ctrl
// Description : ID-stage decode of the miniRV subset into the ID/EX register
//               feeding the ALU, with stall hold, flush bubble and illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module idex_alu_ctrl
    import idex_alu_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alub_sel,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic        ex_illegal
);

    logic        w_bubble;
    logic [31:0] w_inst;
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_bad;
    decode_t     w_dec;
    decode_t     w_dec_fin;
    logic [31:0] w_imm;

    logic        r_valid;
    logic [3:0]  r_alu_op;
    logic        r_alub_sel;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic        r_illegal;

    // Bubbles are produced by decoding the NOP itself, so the slot contents
    // are exactly what a real NOP would have loaded.
    assign w_bubble = flush | ~id_valid;
    assign w_inst   = w_bubble ? NOP_INST : id_inst;

    assign w_opcode = w_inst[6:0];
    assign w_rd     = w_inst[11:7];
    assign w_f3     = w_inst[14:12];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];
    assign w_f7     = w_inst[31:25];

    always_comb begin
        w_bad          = 1'b0;
        w_dec          = DEC_ILLEGAL;
        w_dec.illegal  = 1'b0;
        case (w_opcode)
            OPC_R: begin
                w_dec.rs1 = w_rs1;
                w_dec.rs2 = w_rs2;
                w_dec.rd  = w_rd;
                case (w_f3)
                    F3_ADD: begin
                        if (w_f7 == F7_BASE)     w_dec.alu_op = ALU_ADD;
                        else if (w_f7 == F7_ALT) w_dec.alu_op = ALU_SUB;
                        else                     w_bad        = 1'b1;
                    end
                    F3_SR: begin
                        if (w_f7 == F7_BASE)     w_dec.alu_op = ALU_SRL;
                        else if (w_f7 == F7_ALT) w_dec.alu_op = ALU_SRA;
                        else                     w_bad        = 1'b1;
                    end
                    F3_SLL: begin
                        w_dec.alu_op = ALU_SLL;
                        w_bad        = (w_f7 != F7_BASE);
                    end
                    F3_XOR: begin
                        w_dec.alu_op = ALU_XOR;
                        w_bad        = (w_f7 != F7_BASE);
                    end
                    F3_OR: begin
                        w_dec.alu_op = ALU_OR;
                        w_bad        = (w_f7 != F7_BASE);
                    end
                    F3_AND: begin
                        w_dec.alu_op = ALU_AND;
                        w_bad        = (w_f7 != F7_BASE);
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_I: begin
                w_dec.alub_sel = 1'b1;
                w_dec.imm_type = IMM_I;
                w_dec.rs1      = w_rs1;
                w_dec.rd       = w_rd;
                case (w_f3)
                    F3_ADD: w_dec.alu_op = ALU_ADD;
                    F3_AND: w_dec.alu_op = ALU_AND;
                    F3_OR:  w_dec.alu_op = ALU_OR;
                    F3_XOR: w_dec.alu_op = ALU_XOR;
                    F3_SLL: begin
                        w_dec.alu_op   = ALU_SLL;
                        w_dec.imm_type = IMM_SHAMT;
                        w_bad          = (w_f7 != F7_BASE);
                    end
                    F3_SR: begin
                        w_dec.imm_type = IMM_SHAMT;
                        if (w_f7 == F7_BASE)     w_dec.alu_op = ALU_SRL;
                        else if (w_f7 == F7_ALT) w_dec.alu_op = ALU_SRA;
                        else                     w_bad        = 1'b1;
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_JALR: begin
                w_dec.alub_sel = 1'b1;
                w_dec.imm_type = IMM_I;
                w_dec.rs1      = w_rs1;
                w_dec.rd       = w_rd;
                w_bad          = (w_opcode == OPC_LOAD) ? (w_f3 != F3_LW)
                                                        : (w_f3 != F3_JALR);
            end
            OPC_STORE: begin
                w_dec.alub_sel = 1'b1;
                w_dec.imm_type = IMM_S;
                w_dec.rs1      = w_rs1;
                w_dec.rs2      = w_rs2;
                w_bad          = (w_f3 != F3_SW);
            end
            OPC_BRANCH: begin
                w_dec.alu_op   = ALU_SUB;
                w_dec.imm_type = IMM_B;
                w_dec.rs1      = w_rs1;
                w_dec.rs2      = w_rs2;
                w_bad          = ~is_branch_f3(w_f3);
            end
            OPC_LUI: begin
                w_dec.alub_sel = 1'b1;
                w_dec.imm_type = IMM_U;
                w_dec.rd       = w_rd;
            end
            OPC_JAL: begin
                w_dec.alub_sel = 1'b1;
                w_dec.imm_type = IMM_J;
                w_dec.rd       = w_rd;
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign w_dec_fin = w_bad ? DEC_ILLEGAL : w_dec;

    idex_alu_ctrl_imm_gen u_imm_gen (
        .i_inst     (w_inst),
        .i_imm_type (w_dec_fin.imm_type),
        .o_imm      (w_imm)
    );

    // Flush is folded into w_bubble, so it wins over stall by taking the load path
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_valid    <= 1'b0;
            r_alu_op   <= ALU_ADD;
            r_alub_sel <= 1'b0;
            r_imm      <= 32'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_illegal  <= 1'b0;
        end else if (flush || !stall) begin
            r_valid    <= ~w_bubble;
            r_alu_op   <= w_dec_fin.alu_op;
            r_alub_sel <= w_dec_fin.alub_sel;
            r_imm      <= w_imm;
            r_rs1      <= w_dec_fin.rs1;
            r_rs2      <= w_dec_fin.rs2;
            r_rd       <= w_dec_fin.rd;
            r_illegal  <= w_dec_fin.illegal;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_alu_op   = r_alu_op;
    assign ex_alub_sel = r_alub_sel;
    assign ex_imm      = r_imm;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_illegal  = r_illegal;

endmodule
`default_nettype wire
